// File: rtl/alu_op_dispatcher.sv
// Op FIFO in front of a SimpleALU: issues one op at a time over the ALU's
// Ready busy/done protocol and holds each result in a single output register.
module alu_op_dispatcher #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int INSTR_BIT_WIDTH = 5,
    parameter int FLAGS_COUNT     = 1,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int BUSY_TIMEOUT    = 15,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP = {INSTR_BIT_WIDTH{1'b0}}
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       OpValid,
    output logic                       OpReady,
    input  logic [INSTR_BIT_WIDTH-1:0] OpInstr,
    input  logic [INPUT_BIT_WIDTH-1:0] OpA,
    input  logic [INPUT_BIT_WIDTH-1:0] OpB,
    output logic [INSTR_BIT_WIDTH-1:0] AluInstruction,
    output logic [INPUT_BIT_WIDTH-1:0] AluInputA,
    output logic [INPUT_BIT_WIDTH-1:0] AluInputB,
    input  logic [INPUT_BIT_WIDTH-1:0] AluResultA,
    input  logic [INPUT_BIT_WIDTH-1:0] AluResultB,
    input  logic [FLAGS_COUNT-1:0]     AluFlags,
    input  logic                       AluReady,
    output logic                       ResValid,
    input  logic                       ResReady,
    output logic [INPUT_BIT_WIDTH-1:0] ResA,
    output logic [INPUT_BIT_WIDTH-1:0] ResB,
    output logic [FLAGS_COUNT-1:0]     ResFlags,
    output logic                       ResTimeout,
    output logic [FIFO_DEPTH_LOG2:0]   Pending
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_CAPTURE} state_t;

    logic [INSTR_BIT_WIDTH-1:0] r_q_instr [DEPTH];
    logic [INPUT_BIT_WIDTH-1:0] r_q_a     [DEPTH];
    logic [INPUT_BIT_WIDTH-1:0] r_q_b     [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]              r_count;

    state_t                     r_state, w_state_nx;
    logic [INSTR_BIT_WIDTH-1:0] r_instr, w_instr_nx;
    logic [INPUT_BIT_WIDTH-1:0] r_a, w_a_nx, r_b, w_b_nx;
    logic [TW-1:0]              r_tcnt, w_tcnt_nx, w_tcnt_inc;
    logic                       r_tflag, w_tflag_nx;
    logic                       r_res_valid, w_res_valid_nx;
    logic [INPUT_BIT_WIDTH-1:0] r_res_a, w_res_a_nx, r_res_b, w_res_b_nx;
    logic [FLAGS_COUNT-1:0]     r_res_flags, w_res_flags_nx;
    logic                       r_res_to, w_res_to_nx;
    logic                       w_push, w_pop;

    // Occupancy-based ready: a full FIFO refuses a push even on a popping edge.
    assign OpReady = (r_count < CW'(DEPTH));
    assign w_push  = OpValid && OpReady;
    assign Pending = r_count;

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= OpInstr;
            r_q_a[r_wr_ptr]     <= OpA;
            r_q_b[r_wr_ptr]     <= OpB;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_tcnt_inc = r_tcnt + TW'(1);

    always_comb begin
        w_state_nx      = r_state;
        w_instr_nx      = r_instr;
        w_a_nx          = r_a;
        w_b_nx          = r_b;
        w_tcnt_nx       = r_tcnt;
        w_tflag_nx      = r_tflag;
        w_res_valid_nx  = r_res_valid && !ResReady;
        w_res_a_nx      = r_res_a;
        w_res_b_nx      = r_res_b;
        w_res_flags_nx  = r_res_flags;
        w_res_to_nx     = r_res_to;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_instr_nx = CODE_INSTR_NOP;
                if ((r_count != '0) && AluReady && !r_res_valid) begin
                    w_pop      = 1'b1;
                    w_instr_nx = r_q_instr[r_rd_ptr];
                    w_a_nx     = r_q_a[r_rd_ptr];
                    w_b_nx     = r_q_b[r_rd_ptr];
                    w_tcnt_nx  = '0;
                    w_tflag_nx = 1'b0;
                    w_state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!AluReady) begin
                    w_state_nx = S_BUSY;
                end else begin
                    w_tcnt_nx = w_tcnt_inc;
                    if (w_tcnt_inc == TW'(BUSY_TIMEOUT)) begin
                        w_tflag_nx = 1'b1;
                        w_state_nx = S_CAPTURE;
                    end
                end
            end
            S_BUSY: begin
                if (AluReady) w_state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_res_valid_nx = 1'b1;
                w_res_a_nx     = AluResultA;
                w_res_b_nx     = AluResultB;
                w_res_flags_nx = AluFlags;
                w_res_to_nx    = r_tflag;
                w_instr_nx     = CODE_INSTR_NOP;
                w_state_nx     = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_instr     <= CODE_INSTR_NOP;
            r_a         <= '0;
            r_b         <= '0;
            r_tcnt      <= '0;
            r_tflag     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_a     <= '0;
            r_res_b     <= '0;
            r_res_flags <= '0;
            r_res_to    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_instr     <= w_instr_nx;
            r_a         <= w_a_nx;
            r_b         <= w_b_nx;
            r_tcnt      <= w_tcnt_nx;
            r_tflag     <= w_tflag_nx;
            r_res_valid <= w_res_valid_nx;
            r_res_a     <= w_res_a_nx;
            r_res_b     <= w_res_b_nx;
            r_res_flags <= w_res_flags_nx;
            r_res_to    <= w_res_to_nx;
        end
    end

    assign AluInstruction = r_instr;
    assign AluInputA      = r_a;
    assign AluInputB      = r_b;
    assign ResValid       = r_res_valid;
    assign ResA           = r_res_a;
    assign ResB           = r_res_b;
    assign ResFlags       = r_res_flags;
    assign ResTimeout     = r_res_to;

endmodule

// File: doc/alu_op_dispatcher.md
Name: alu_op_dispatcher

Overview:
- Upstream feeder for the SimpleALU.
- Accepts operations (instruction plus two operands) through a valid/ready handshake and buffers them in a small FIFO.
- Issues one operation at a time using the ALU's Ready busy/done protocol, then presents the captured results downstream through a single-entry output register with valid/ready handshake.
- Sits between the instruction source (decoder/test driver) and the ALU, and between the ALU and writeback.

Parameters:
- INPUT_BIT_WIDTH, 8, operand/result width.
- INSTR_BIT_WIDTH, 5, instruction code width.
- FLAGS_COUNT, 1, ALU flag vector width.
- FIFO_DEPTH_LOG2, 2, log2 of op FIFO depth (default depth 4).
- BUSY_TIMEOUT, 15, max cycles to wait for AluReady to fall after issue.
- CODE_INSTR_NOP, 5'b00000, code driven to ALU when idle.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- OpValid  in  1  upstream op valid.
- OpReady  out  1  FIFO can accept (not full).
- OpInstr  in  INSTR_BIT_WIDTH  instruction code.
- OpA  in  INPUT_BIT_WIDTH  operand A.
- OpB  in  INPUT_BIT_WIDTH  operand B.
- AluInstruction  out  INSTR_BIT_WIDTH  to ALU Instruction.
- AluInputA  out  INPUT_BIT_WIDTH  to ALU InputA.
- AluInputB  out  INPUT_BIT_WIDTH  to ALU InputB.
- AluResultA  in  INPUT_BIT_WIDTH  from ALU ResultA.
- AluResultB  in  INPUT_BIT_WIDTH  from ALU ResultB.
- AluFlags  in  FLAGS_COUNT  from ALU Flags.
- AluReady  in  1  ALU Ready (1 = idle/done).
- ResValid  out  1  result register holds a result.
- ResReady  in  1  downstream accepts result.
- ResA  out  INPUT_BIT_WIDTH  captured ResultA.
- ResB  out  INPUT_BIT_WIDTH  captured ResultB.
- ResFlags  out  FLAGS_COUNT  captured Flags.
- ResTimeout  out  1  result was taken on timeout, not a real busy/done cycle.
- Pending  out  FIFO_DEPTH_LOG2+1  FIFO occupancy.

Behaviour:
Reset (async, active-high):
- FIFO empty, Pending=0, OpReady=1.
- State=IDLE.
- AluInstruction=CODE_INSTR_NOP, AluInputA=0, AluInputB=0.
- ResValid=0, ResA=0, ResB=0, ResFlags=0, ResTimeout=0.
- Timeout counter=0.
- Reset mid-operation discards all queued and in-flight ops; no result is produced.

FIFO:
- Push on OpValid&&OpReady.
- OpReady = Pending < 2^FIFO_DEPTH_LOG2.
- Pop when the FSM leaves IDLE to ISSUE.
- Simultaneous push and pop on a full FIFO: the push is refused, since OpReady is based on registered occupancy.
- Pointers wrap modulo depth.
- Pending updates on the same edge as push/pop; push+pop leaves it unchanged.

FSM (registered outputs, one transition per edge):
- IDLE: if FIFO non-empty && AluReady==1 && ResValid==0, pop the head, load AluInstruction/AluInputA/AluInputB, clear the timeout counter, go to ISSUE. Otherwise drive NOP.
- ISSUE: hold ALU outputs stable. If AluReady==0, go to BUSY. Else increment the counter; when the counter reaches BUSY_TIMEOUT, go to CAPTURE with the timeout flag set.
- BUSY: hold ALU outputs stable until AluReady==1, then go to CAPTURE. No timeout applies in BUSY.
- CAPTURE:
  - Register AluResultA/B/Flags into ResA/ResB/ResFlags.
  - Set ResValid=1 and ResTimeout to the timeout flag.
  - Drive AluInstruction=CODE_INSTR_NOP.
  - Go to IDLE.
- Operands remain unchanged after CAPTURE until the next issue.

Output handshake:
- ResValid clears on ResValid&&ResReady.
- A new issue is blocked while ResValid=1, so results are never overwritten and stay in FIFO order.
- Capture happens only when ResValid=0, so there is no capture/consume collision.

Latency:
- Minimum from OpValid accept (FIFO empty, ALU idle) to ResValid=1 is push edge, plus IDLE→ISSUE edge, plus ALU busy time, plus BUSY→CAPTURE edge, plus the CAPTURE edge.
- Back-to-back ops need at least one NOP cycle in IDLE between issues.

Test Plan:
- Single ADD 15,7 with a SimpleALU model → ResValid=1, ResA=22, ResTimeout=0. AluInstruction returns to NOP after capture.
- Push ADD(15,7), SUB(15,7), MUL(15,7), DIV(15,7) back-to-back, ResReady=1 → results 22, 8, 105, 2 in order. OpReady never drops, since depth is 4.
- Push 5 ops while AluReady is held 0, then release → OpReady=0 after 4 accepts (Pending=4). The 5th is accepted only after the first pop. All 5 results arrive in order.
- Backpressure: ResReady=0 after the first result → ResA stays 22 and no new issue occurs (AluInstruction=NOP). Raise ResReady → the next op issues and its result is 8.
- Stuck-ready ALU (AluReady tied 1, ResultA=0x55), issue OR → after BUSY_TIMEOUT (15) cycles ResValid=1, ResA=0x55, ResTimeout=1.
- Assert Reset during BUSY with 2 ops queued → next edge: Pending=0, ResValid=0, AluInstruction=NOP. After release no stale result appears.
